// File: rtl/eva_ahb_mem_slv.sv
// AHB-lite slave memory model: byte-lane writes, write-to-read forwarding, configurable wait states.
// Define EVA_AHB_MEM_ECHK_EN to return two-cycle ERROR on bad size, misalignment or out-of-range address.
module eva_ahb_mem_slv #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WAIT  = 0
) (
   input  logic          hclk,
   input  logic          hrst_n,
   input  logic          hsel,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [31:0]   haddr,
   input  logic [2:0]    hsize,
   input  logic [2:0]    hburst,
   input  logic [3:0]    hprot,
   input  logic [DW-1:0] hwdata,
   input  logic          hready_in,
   output logic          hready_out,
   output logic [1:0]    hresp,
   output logic [DW-1:0] hrdata
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned LB = $clog2(BW);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA
`ifdef EVA_AHB_MEM_ECHK_EN
      , S_ERR1,
      S_ERR2
`endif
   } state_e;

   state_e          state_q, state_d, acc_state;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q;
   logic [BW-1:0]   be_q;
   logic            wr_q;
   logic            hready_q, hready_d;
   logic [1:0]      hresp_q, hresp_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            accept;
   logic            err;
   logic [2:0]      sz_eff;
   logic [LB-1:0]   lowmask;
   logic [LB-1:0]   off;
   logic [AW-1:0]   widx;
   logic [BW-1:0]   be;
   logic [DW-1:0]   rd_word;
   logic            unused_ok;

   assign unused_ok = ^{hburst, hprot, htrans[0], haddr};

   // Address-phase decode: accept, error, word index and byte-lane enables
   always_comb begin
      accept  = hsel & hready_in & htrans[1] & hready_q;
      sz_eff  = (hsize > 3'(LB)) ? 3'(LB) : hsize;
      lowmask = LB'((32'd1 << sz_eff) - 32'd1);
      widx    = haddr[LB+AW-1:LB];
`ifdef EVA_AHB_MEM_ECHK_EN
      off     = haddr[LB-1:0];
      err     = (hsize > 3'(LB)) | (|(haddr[LB-1:0] & lowmask)) | (haddr >= 32'(DEPTH * BW));
`else
      off     = haddr[LB-1:0] & ~lowmask;
      err     = 1'b0;
`endif
      be = '0;
      for (int unsigned i = 0; i < BW; i++) begin
         be[i] = (i >= 32'(off)) && (i < (32'(off) + (32'd1 << sz_eff)));
      end
   end

   // Read fetch, with bytes of a write completing this cycle to the same word merged in
   always_comb begin
      rd_word = mem_q[widx];
      if (state_q == S_DATA && wr_q && addr_q == widx) begin
         for (int unsigned i = 0; i < BW; i++) begin
            if (be_q[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      acc_state = S_DATA;
`ifdef EVA_AHB_MEM_ECHK_EN
      if (err) acc_state = S_ERR1;
      else
`endif
      if (WAIT > 0) acc_state = S_WAIT;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE, S_DATA: begin
            state_d = accept ? acc_state : S_IDLE;
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_DATA;
            else             cnt_d   = cnt_q - CW'(1);
         end
`ifdef EVA_AHB_MEM_ECHK_EN
         S_ERR1: state_d = S_ERR2;
         S_ERR2: state_d = accept ? acc_state : S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
      if (accept && state_d == S_WAIT) cnt_d = CW'(WAIT - 1);
      if (accept && !err && !hwrite)   rdata_d = rd_word;

      hready_d = (state_d != S_WAIT);
      hresp_d  = 2'd0;
`ifdef EVA_AHB_MEM_ECHK_EN
      if (state_d == S_ERR1) hready_d = 1'b0;
      if (state_d == S_ERR1 || state_d == S_ERR2) hresp_d = 2'd1;
`endif
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wr_q     <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= 2'd0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         rdata_q  <= rdata_d;
         if (accept) begin
            addr_q <= widx;
            be_q   <= be;
            wr_q   <= hwrite & ~err;
         end
      end
   end

   // Storage array has no reset so contents survive a bus reset
   always_ff @(posedge hclk) begin
      if (state_q == S_DATA && wr_q) begin
         for (int unsigned i = 0; i < BW; i++) begin
            if (be_q[i]) mem_q[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   assign hready_out = hready_q;
   assign hresp      = hresp_q;
   assign hrdata     = rdata_q;

endmodule

// File: tb/tb_eva_ahb_mem_slv.sv
// Directed bench: three instances (32b/0 wait, 32b/3 wait, 64b/0 wait) sharing one driven bus.
// Expectations follow EVA_AHB_MEM_ECHK_EN when it is defined for the build.
module tb_eva_ahb_mem_slv;

   logic        hclk;
   logic        hrst_n;
   logic [2:0]  sel;
   logic [1:0]  trans;
   logic        write;
   logic [31:0] addr;
   logic [2:0]  size;
   logic [63:0] wdata;

   logic        rdy0, rdy1, rdy2;
   logic [1:0]  resp0, resp1, resp2;
   logic [31:0] rd0, rd1;
   logic [63:0] rd2;

   int n_chk  = 0;
   int n_fail = 0;
   int lo0    = 0;
   int n;

`ifdef EVA_AHB_MEM_ECHK_EN
   localparam bit ECHK = 1'b1;
`else
   localparam bit ECHK = 1'b0;
`endif

   eva_ahb_mem_slv #(.DW(32), .DEPTH(64), .WAIT(0)) u_w0 (
      .hclk(hclk), .hrst_n(hrst_n), .hsel(sel[0]), .htrans(trans), .hwrite(write),
      .haddr(addr), .hsize(size), .hburst(3'd0), .hprot(4'd0), .hwdata(wdata[31:0]),
      .hready_in(rdy0), .hready_out(rdy0), .hresp(resp0), .hrdata(rd0));

   eva_ahb_mem_slv #(.DW(32), .DEPTH(64), .WAIT(3)) u_w3 (
      .hclk(hclk), .hrst_n(hrst_n), .hsel(sel[1]), .htrans(trans), .hwrite(write),
      .haddr(addr), .hsize(size), .hburst(3'd0), .hprot(4'd0), .hwdata(wdata[31:0]),
      .hready_in(rdy1), .hready_out(rdy1), .hresp(resp1), .hrdata(rd1));

   eva_ahb_mem_slv #(.DW(64), .DEPTH(64), .WAIT(0)) u_d64 (
      .hclk(hclk), .hrst_n(hrst_n), .hsel(sel[2]), .htrans(trans), .hwrite(write),
      .haddr(addr), .hsize(size), .hburst(3'd0), .hprot(4'd0), .hwdata(wdata),
      .hready_in(rdy2), .hready_out(rdy2), .hresp(resp2), .hrdata(rd2));

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Low-ready cycles on the zero-wait instance
   always @(negedge hclk) if (hrst_n && !rdy0) lo0++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic ap(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz);
      sel    = '0;
      sel[d] = 1'b1;
      trans  = 2'd2;
      write  = wr;
      addr   = a;
      size   = sz;
   endtask

   task automatic idle();
      sel   = '0;
      trans = 2'd0;
      write = 1'b0;
   endtask

   // Counts hready_out-low cycles on the wait-state instance, bounded
   task automatic wait_rdy1(output int cnt);
      cnt = 0;
      while (rdy1 == 1'b0 && cnt < 20) begin
         cnt++;
         step();
      end
   endtask

   initial begin
      hrst_n = 1'b1;
      idle();
      addr   = '0;
      size   = '0;
      wdata  = '0;
      #2 hrst_n = 1'b0;
      #1;
      check("rst_rdy",  {61'd0, rdy0, rdy1, rdy2}, 64'h7);
      check("rst_resp", {58'd0, resp0, resp1, resp2}, 64'h0);
      check("rst_rd0",  64'(rd0), 64'h0);
      check("rst_rd2",  rd2, 64'h0);
      step();
      step();
      hrst_n = 1'b1;
      step();

      // Zero-wait pipelined write then forwarded read
      ap(0, 1'b1, 32'h10, 3'd2);
      step();
      wdata = 64'hDEADBEEF;
      ap(0, 1'b0, 32'h10, 3'd2);
      check("fw_wr_rdy", 64'(rdy0), 64'h1);
      step();
      idle();
      check("fw_rd", 64'(rd0), 64'hDEADBEEF);
      check("fw_resp", 64'(resp0), 64'h0);
      step();
      check("fw_hold", 64'(rd0), 64'hDEADBEEF);

      // Back-to-back writes: full word, byte lane, halfword
      ap(0, 1'b1, 32'h00, 3'd2);
      step();
      wdata = 64'h0BADF00D;
      ap(0, 1'b1, 32'h14, 3'd2);
      step();
      wdata = 64'h12345678;
      ap(0, 1'b1, 32'h11, 3'd0);
      step();
      wdata = 64'hAABB5ACC;
      ap(0, 1'b1, 32'h16, 3'd1);
      step();
      wdata = 64'hCAFE1234;
      idle();
      step();
      ap(0, 1'b0, 32'h10, 3'd2);
      step();
      idle();
      check("byte_wr", 64'(rd0), 64'hDEAD5AEF);
      ap(0, 1'b0, 32'h14, 3'd2);
      step();
      idle();
      check("half_wr", 64'(rd0), 64'hCAFE5678);
      step();

      // Misaligned word read
      ap(0, 1'b0, 32'h12, 3'd2);
      step();
      idle();
      if (ECHK) begin
         check("mis_err1", {62'd0, rdy0, resp0[0]}, 64'h1);
         step();
         check("mis_err2", {62'd0, rdy0, resp0[0]}, 64'h3);
         step();
         check("mis_rd", 64'(rd0), 64'hCAFE5678);
      end else begin
         check("mis_rd", 64'(rd0), 64'hDEAD5AEF);
         check("mis_resp", 64'(resp0), 64'h0);
         step();
      end

      // Out-of-range write, then read word 0
      ap(0, 1'b1, 32'h100, 3'd2);
      step();
      wdata = 64'hFFFFFFFF;
      idle();
      if (ECHK) begin
         check("oob_err1", {62'd0, rdy0, resp0[0]}, 64'h1);
         step();
         check("oob_err2", {62'd0, rdy0, resp0[0]}, 64'h3);
      end
      step();
      ap(0, 1'b0, 32'h00, 3'd2);
      step();
      idle();
      check("oob_rd", 64'(rd0), ECHK ? 64'h0BADF00D : 64'hFFFFFFFF);
      check("oob_resp", 64'(resp0), 64'h0);
      step();
      check("w0_low_cycles", 64'(lo0), ECHK ? 64'd2 : 64'd0);

      // 64-bit: preload, byte-lane write, forwarded read
      ap(2, 1'b1, 32'h08, 3'd3);
      step();
      wdata = 64'h1122334455667788;
      ap(2, 1'b1, 32'h0B, 3'd0);
      step();
      wdata = 64'hFFFFFFFFA5FFFFFF;
      ap(2, 1'b0, 32'h08, 3'd3);
      step();
      idle();
      check("d64_fw", rd2, 64'h11223344A5667788);
      step();
      ap(2, 1'b1, 32'h00, 3'd3);
      step();
      wdata = 64'h0123456789ABCDEF;
      ap(2, 1'b0, 32'h00, 3'd3);
      step();
      idle();
      check("d64_rd0", rd2, 64'h0123456789ABCDEF);
      ap(2, 1'b0, 32'h0C, 3'd3);
      step();
      idle();
      if (ECHK) begin
         check("d64_mis_err", {62'd0, rdy2, resp2[0]}, 64'h1);
         step();
         step();
         check("d64_mis_rd", rd2, 64'h0123456789ABCDEF);
      end else begin
         check("d64_mis_rd", rd2, 64'h11223344A5667788);
         step();
      end
      ap(2, 1'b0, 32'h0C, 3'd2);
      step();
      idle();
      check("d64_mem", rd2, 64'h11223344A5667788);
      step();

      // Wait states: write then read 0x20
      ap(1, 1'b1, 32'h20, 3'd2);
      step();
      wdata = 64'h5555AAAA;
      idle();
      wait_rdy1(n);
      check("ws_wr_low", 64'(n), 64'd3);
      step();
      check("ws_wr_done", 64'(rdy1), 64'h1);
      ap(1, 1'b0, 32'h20, 3'd2);
      step();
      idle();
      wait_rdy1(n);
      check("ws_rd_low", 64'(n), 64'd3);
      check("ws_rd", 64'(rd1), 64'h5555AAAA);
      check("ws_resp", 64'(resp1), 64'h0);
      step();

      // Address phase held during wait states is accepted once, on completion
      ap(1, 1'b0, 32'h20, 3'd2);
      step();
      ap(1, 1'b1, 32'h24, 3'd2);
      wait_rdy1(n);
      check("stall_low1", 64'(n), 64'd3);
      step();
      wdata = 64'h13579BDF;
      idle();
      wait_rdy1(n);
      check("stall_low2", 64'(n), 64'd3);
      step();
      ap(1, 1'b0, 32'h24, 3'd2);
      step();
      idle();
      wait_rdy1(n);
      check("stall_rd", 64'(rd1), 64'h13579BDF);
      step();

      // Asynchronous reset during wait states
      ap(1, 1'b0, 32'h20, 3'd2);
      step();
      idle();
      #2 hrst_n = 1'b0;
      #1;
      check("arst_rdy", 64'(rdy1), 64'h1);
      check("arst_resp", 64'(resp1), 64'h0);
      check("arst_rd1", 64'(rd1), 64'h0);
      step();
      hrst_n = 1'b1;
      step();
      ap(1, 1'b0, 32'h24, 3'd2);
      step();
      idle();
      wait_rdy1(n);
      check("keep_w3", 64'(rd1), 64'h13579BDF);
      step();
      ap(0, 1'b0, 32'h14, 3'd2);
      step();
      idle();
      check("keep_w0", 64'(rd0), 64'hCAFE5678);
      ap(2, 1'b0, 32'h08, 3'd3);
      step();
      idle();
      check("keep_d64", rd2, 64'h11223344A5667788);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
